turf_udp_port_demux: RTL

Receive-side UDP port demultiplexer sitting directly downstream of the TURF UDP core's received-header and received-payload streams. Each datagram header is registered and its destination port is matched against a parameterized port list. A matched datagram's header and payload are steered to one of NUM_PORTS per-port output streams. An unmatched datagram's payload is consumed and discarded, and a saturating drop counter is incremented.

---
 rtl/turf_udp_port_demux.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/turf_udp_port_demux.sv
// Receive-side UDP destination-port demultiplexer: steers each datagram's header
// and payload to the channel whose port matches, or discards and counts it.
module turf_udp_port_demux #(
    parameter int                        NUM_PORTS = 4,
    // Entry i lives at [16*i +: 16]; entry 0 is the rightmost field.
    parameter logic [NUM_PORTS*16-1:0]   PORT_LIST = {16'd21843, 16'd21847, 16'd21622, 16'd21618}
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [63:0]           s_udphdr_tdata,
    input  logic [15:0]           s_udphdr_tdest,
    input  logic                  s_udphdr_tvalid,
    output logic                  s_udphdr_tready,

    input  logic [63:0]           s_udpdata_tdata,
    input  logic [7:0]            s_udpdata_tkeep,
    input  logic                  s_udpdata_tlast,
    input  logic                  s_udpdata_tvalid,
    output logic                  s_udpdata_tready,

    output logic [63:0]           m_hdr_tdata,
    output logic [NUM_PORTS-1:0]  m_hdr_tvalid,
    input  logic [NUM_PORTS-1:0]  m_hdr_tready,

    output logic [63:0]           m_data_tdata,
    output logic [7:0]            m_data_tkeep,
    output logic                  m_data_tlast,
    output logic [NUM_PORTS-1:0]  m_data_tvalid,
    input  logic [NUM_PORTS-1:0]  m_data_tready,

    output logic [15:0]           drop_count
);

    localparam int SEL_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA,
        DROP
    } state_t;

    state_t                 r_state;
    logic [SEL_W-1:0]       r_sel;
    logic [63:0]            r_hdr_tdata;
    logic [NUM_PORTS-1:0]   r_hdr_tvalid;
    logic [15:0]            r_drop_count;

    logic [NUM_PORTS-1:0]   w_hit;
    logic [NUM_PORTS-1:0]   w_sel_oh;
    logic [NUM_PORTS-1:0]   w_match_oh;
    logic [SEL_W-1:0]       w_match_idx;
    logic                   w_match;
    logic                   w_hdr_fire;
    logic                   w_hdr_ack;
    logic                   w_sel_ready;
    logic                   w_last_fire;

    // A zero entry is a disabled slot and must never match, even for tdest 0.
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign w_hit[gi]    = (PORT_LIST[16*gi +: 16] != 16'h0000) &&
                                  (PORT_LIST[16*gi +: 16] == s_udphdr_tdest);
            assign w_sel_oh[gi] = (r_sel == SEL_W'(gi));
        end
    endgenerate

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        w_match     = 1'b0;
        w_match_idx = '0;
        w_match_oh  = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_match       = 1'b1;
                w_match_idx   = SEL_W'(i);
                w_match_oh    = '0;
                w_match_oh[i] = 1'b1;
            end
        end
    end

    assign s_udphdr_tready  = (r_state == IDLE);
    assign w_hdr_fire       = s_udphdr_tvalid && s_udphdr_tready;
    assign w_hdr_ack        = |(r_hdr_tvalid & m_hdr_tready);
    assign w_sel_ready      = |(m_data_tready & w_sel_oh);

    assign s_udpdata_tready = (r_state == DATA) ? w_sel_ready : (r_state == DROP);
    assign w_last_fire      = s_udpdata_tvalid && s_udpdata_tready && s_udpdata_tlast;

    assign m_hdr_tdata      = r_hdr_tdata;
    assign m_hdr_tvalid     = r_hdr_tvalid;
    assign m_data_tdata     = s_udpdata_tdata;
    assign m_data_tkeep     = s_udpdata_tkeep;
    assign m_data_tlast     = s_udpdata_tlast;
    assign m_data_tvalid    = ((r_state == DATA) && s_udpdata_tvalid) ? w_sel_oh : '0;
    assign drop_count       = r_drop_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_sel        <= '0;
            r_hdr_tdata  <= '0;
            r_hdr_tvalid <= '0;
            r_drop_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hdr_fire) begin
                        r_hdr_tdata <= s_udphdr_tdata;
                        r_sel       <= w_match_idx;
                        if (w_match) begin
                            r_hdr_tvalid <= w_match_oh;
                            r_state      <= HDR;
                        end else begin
                            r_state      <= DROP;
                        end
                    end
                end
                HDR: begin
                    if (w_hdr_ack) begin
                        r_hdr_tvalid <= '0;
                        r_state      <= DATA;
                    end
                end
                DATA: begin
                    if (w_last_fire) begin
                        r_state <= IDLE;
                    end
                end
                DROP: begin
                    if (w_last_fire) begin
                        if (r_drop_count != 16'hFFFF) begin
                            r_drop_count <= r_drop_count + 16'd1;
                        end
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
